// File: rtl/font_pkg.sv
// Constants and the lookup tag type shared across the font glyph path.
package font_pkg;
    localparam int GLYPH_LAT    = 4;
    localparam int MISSING_ADDR = 'h11;
    localparam int REPLACE_ADDR = 'h7F;

    // Id field sized for the largest supported requester count (8).
    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } glyph_tag_t;
endpackage

// File: rtl/font_glyph_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr wins; next_ptr is the slot after the winner.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any,
    output logic [PW-1:0] next_ptr
);
    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int o = 0; o < N; o++) begin
            c = int'(ptr) + o;
            if (c >= N) c = c - N;
            if (!any && req[c]) begin
                any     = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = PW'(c);
            end
        end
        next_ptr = PW'((int'(gnt_idx) + 1) % N);
    end
endmodule

// File: rtl/font_glyph_arbiter.sv
// Shares one fixed-latency glyph lookup pipeline among REQS requesters and routes results back by tag.
// Build option FONT_GLYPH_ARBITER_STATS_EN adds per-requester grant and starvation-grant counters.
module font_glyph_arbiter #(
    parameter int REQS       = 3,
    parameter int UCPW       = 21,
    parameter int HEIGHT     = 16,
    parameter int WIDTH      = 8,
    parameter int GLYPH_LAT  = font_pkg::GLYPH_LAT,
    parameter int STARVE_MAX = 15,
    localparam int LW        = $clog2(HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQS-1:0]      req_valid,
    output logic [REQS-1:0]      req_ready,
    input  logic [REQS*UCPW-1:0] req_ucp,
    input  logic [REQS*LW-1:0]   req_line,
    output logic [REQS-1:0]      rsp_valid,
    output logic [WIDTH-1:0]     rsp_pix,
    output logic [UCPW-1:0]      glyph_ucp,
    output logic [LW-1:0]        glyph_line,
    input  logic [WIDTH-1:0]     glyph_pix
`ifdef FONT_GLYPH_ARBITER_STATS_EN
   ,output logic [REQS*16-1:0]   stat_grants,
    output logic [REQS*16-1:0]   stat_starve
`endif
);
    import font_pkg::*;

    localparam int         IDW       = $clog2(REQS);
    localparam int         NRR       = REQS - 1;
    localparam int         PW        = (NRR > 1) ? $clog2(NRR) : 1;
    localparam logic [7:0] STARVE_TC = 8'(STARVE_MAX);

    logic [7:0]      starve_cnt [REQS-1:1];
    logic [REQS-1:1] starved;
    // Pointer is held relative to requester 1 (0 means requester 1).
    logic [PW-1:0]   rr_ptr, rr_ptr_nxt, rr_next, rr_idx;
    logic [NRR-1:0]  rr_gnt;
    logic            rr_any;
    logic [REQS-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic            via_starve;
    glyph_tag_t      tag_q [GLYPH_LAT];

    always_comb begin
        starved = '0;
        for (int j = 1; j < REQS; j++)
            starved[j] = req_valid[j] && (starve_cnt[j] == STARVE_TC);
    end

    rr_pick #(.N(NRR), .PW(PW)) u_rr_pick (
        .req      (req_valid[REQS-1:1]),
        .ptr      (rr_ptr),
        .gnt      (rr_gnt),
        .gnt_idx  (rr_idx),
        .any      (rr_any),
        .next_ptr (rr_next)
    );

    always_comb begin
        gnt        = '0;
        gnt_id     = '0;
        gnt_any    = 1'b0;
        via_starve = 1'b0;
        rr_ptr_nxt = rr_ptr;
        // Descending scan so the lowest starved index is the one left standing.
        for (int j = REQS - 1; j >= 1; j--) begin
            if (starved[j]) begin
                via_starve = 1'b1;
                gnt_id     = IDW'(j);
            end
        end
        if (!rst_n) begin
            gnt_id     = '0;
            via_starve = 1'b0;
        end else if (via_starve) begin
            gnt_any     = 1'b1;
            gnt[gnt_id] = 1'b1;
            rr_ptr_nxt  = PW'(int'(gnt_id) % NRR);
        end else if (req_valid[0]) begin
            gnt_any = 1'b1;
            gnt[0]  = 1'b1;
        end else if (rr_any) begin
            gnt_any         = 1'b1;
            gnt[REQS-1:1]   = rr_gnt;
            gnt_id          = IDW'(int'(rr_idx) + 1);
            rr_ptr_nxt      = rr_next;
        end
    end

    assign req_ready  = gnt;
    assign glyph_ucp  = gnt_any ? req_ucp[int'(gnt_id)*UCPW +: UCPW] : '0;
    assign glyph_line = gnt_any ? req_line[int'(gnt_id)*LW +: LW] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            for (int j = 1; j < REQS; j++) starve_cnt[j] <= '0;
            for (int i = 0; i < GLYPH_LAT; i++) tag_q[i] <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
            for (int j = 1; j < REQS; j++) begin
                if (!req_valid[j] || gnt[j])
                    starve_cnt[j] <= '0;
                else if (starve_cnt[j] != STARVE_TC)
                    starve_cnt[j] <= starve_cnt[j] + 8'd1;
            end
            tag_q[0] <= '{valid: gnt_any, id: TAG_IDW'(gnt_id)};
            for (int i = 1; i < GLYPH_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < REQS; i++)
            rsp_valid[i] = tag_q[GLYPH_LAT-1].valid && (tag_q[GLYPH_LAT-1].id == TAG_IDW'(i));
    end

    assign rsp_pix = glyph_pix;

`ifdef FONT_GLYPH_ARBITER_STATS_EN
    logic [15:0] grant_cnt      [REQS];
    logic [15:0] starve_gnt_cnt [REQS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQS; i++) begin
                grant_cnt[i]      <= '0;
                starve_gnt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQS; i++) begin
                if (gnt[i]) grant_cnt[i] <= grant_cnt[i] + 16'd1;
                if (gnt[i] && via_starve) starve_gnt_cnt[i] <= starve_gnt_cnt[i] + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < REQS; i++) begin : g_stat
        assign stat_grants[i*16 +: 16] = grant_cnt[i];
        assign stat_starve[i*16 +: 16] = starve_gnt_cnt[i];
    end
`else
    logic unused_via_starve;
    assign unused_via_starve = via_starve;
`endif
endmodule

// File: tb/tb_font_glyph_arbiter.sv
// Scoreboard bench for font_glyph_arbiter with a stand-in glyph pipeline and a rule-level grant model.
module tb_font_glyph_arbiter;
    localparam int REQS        = 3;
    localparam int UCPW        = 21;
    localparam int HEIGHT      = 16;
    localparam int LW          = 4;
    localparam int WIDTH       = 8;
    localparam int LAT         = 4;
    localparam int STARVE_MAX  = 15;
    localparam int MISSING_IDX = 'h11;

    logic                 clk;
    logic                 rst_n;
    logic [REQS-1:0]      req_valid;
    logic [REQS-1:0]      req_ready;
    logic [REQS*UCPW-1:0] req_ucp;
    logic [REQS*LW-1:0]   req_line;
    logic [REQS-1:0]      rsp_valid;
    logic [WIDTH-1:0]     rsp_pix;
    logic [UCPW-1:0]      glyph_ucp;
    logic [LW-1:0]        glyph_line;
    logic [WIDTH-1:0]     glyph_pix;
`ifdef FONT_GLYPH_ARBITER_STATS_EN
    logic [REQS*16-1:0]   stat_grants;
    logic [REQS*16-1:0]   stat_starve;
`endif

    font_glyph_arbiter #(
        .REQS(REQS), .UCPW(UCPW), .HEIGHT(HEIGHT), .WIDTH(WIDTH),
        .GLYPH_LAT(LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ucp(req_ucp), .req_line(req_line),
        .rsp_valid(rsp_valid), .rsp_pix(rsp_pix),
        .glyph_ucp(glyph_ucp), .glyph_line(glyph_line), .glyph_pix(glyph_pix)
`ifdef FONT_GLYPH_ARBITER_STATS_EN
       ,.stat_grants(stat_grants), .stat_starve(stat_starve)
`endif
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    typedef struct {
        int             id;
        logic [WIDTH-1:0] pix;
        int             due;
    } exp_t;
    exp_t exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Printable ASCII has its own glyph; everything else shows the missing-glyph box.
    function automatic logic [WIDTH-1:0] glyph_fn(input logic [UCPW-1:0] ucp, input logic [LW-1:0] line);
        int a, r;
        a = (ucp >= 21'h20 && ucp <= 21'h7E) ? int'(ucp) : MISSING_IDX;
        r = a * 37 + int'(line) * 11 + ((a ^ int'(line)) << 2);
        return WIDTH'(r ^ 'h5A);
    endfunction

    logic [WIDTH-1:0] gp [LAT];
    always @(posedge clk) begin
        gp[0] <= glyph_fn(glyph_ucp, glyph_line);
        for (int i = 1; i < LAT; i++) gp[i] <= gp[i-1];
    end
    assign glyph_pix = gp[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: waiting-time per requester and the next round-robin favourite.
    int wait_cnt [REQS];
    int rr_next;

    task automatic model_reset();
        for (int i = 0; i < REQS; i++) wait_cnt[i] = 0;
        rr_next = 1;
    endtask

    function automatic int model_pick(input logic [REQS-1:0] v);
        for (int j = 1; j < REQS; j++)
            if (v[j] && wait_cnt[j] == STARVE_MAX) return j;
        if (v[0]) return 0;
        for (int o = 0; o < REQS - 1; o++) begin
            int k;
            k = 1 + ((rr_next - 1 + o) % (REQS - 1));
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [REQS-1:0] v, input int g);
        for (int j = 1; j < REQS; j++)
            wait_cnt[j] = (v[j] && g != j) ? ((wait_cnt[j] < STARVE_MAX) ? wait_cnt[j] + 1 : STARVE_MAX) : 0;
        if (g >= 1) rr_next = (g % (REQS - 1)) + 1;
    endtask

    logic [REQS-1:0] cur_v;
    logic [UCPW-1:0] cur_ucp  [REQS];
    logic [LW-1:0]   cur_line [REQS];
    int              last_gnt = -1;

    task automatic new_fields(input int i);
        if ($urandom_range(0, 3) == 0) cur_ucp[i] = UCPW'($urandom);
        else                           cur_ucp[i] = UCPW'($urandom_range('h20, 'h7E));
        cur_line[i] = LW'($urandom_range(0, HEIGHT - 1));
    endtask

    task automatic set_hold(input logic [REQS-1:0] mask);
        for (int i = 0; i < REQS; i++)
            if (mask[i] && (!cur_v[i] || last_gnt == i)) new_fields(i);
        cur_v = mask;
    endtask

    task automatic random_next();
        for (int i = 0; i < REQS; i++) begin
            if (!(cur_v[i] && last_gnt != i)) begin
                cur_v[i] = (i == 0) ? ($urandom_range(0, 9) < 7) : 1'($urandom_range(0, 1));
                if (cur_v[i]) new_fields(i);
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic issue_cycle(output logic [REQS-1:0] rdy);
        logic [REQS-1:0] exp_rdy;
        exp_t            e;
        int              g;
        for (int i = 0; i < REQS; i++) begin
            req_ucp[i*UCPW +: UCPW] = cur_ucp[i];
            req_line[i*LW +: LW]    = cur_line[i];
        end
        req_valid = cur_v;
        #1;
        rdy = req_ready;
        g = model_pick(cur_v);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        if (g >= 0) begin
            check("glyph_ucp", glyph_ucp, cur_ucp[g]);
            check("glyph_line", glyph_line, cur_line[g]);
            e.id  = g;
            e.pix = glyph_fn(cur_ucp[g], cur_line[g]);
            e.due = cyc + LAT;
            exp_q.push_back(e);
        end else begin
            check("glyph_idle", {glyph_ucp, glyph_line}, '0);
        end
        model_update(cur_v, g);
        last_gnt = g;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic [REQS-1:0] r;
        cur_v = '0;
        repeat (n) issue_cycle(r);
    endtask

    task automatic do_reset();
        req_valid = '1;
        #3 rst_n = 1'b0;
        #1;
        check("rst_ready", req_ready, '0);
        check("rst_rsp", rsp_valid, '0);
        check("rst_glyph", {glyph_ucp, glyph_line}, '0);
        exp_q.delete();
        model_reset();
        cur_v    = '0;
        last_gnt = -1;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
    endtask

    // Monitor: pops the scoreboard whenever a response is due, else expects silence.
    initial begin
        exp_t e;
        logic [REQS-1:0] onehot;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                check("rsp_in_reset", rsp_valid, '0);
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                onehot = '0;
                onehot[e.id] = 1'b1;
                check("rsp_valid", rsp_valid, onehot);
                check("rsp_pix", rsp_pix, e.pix);
            end else begin
                check("rsp_idle", rsp_valid, '0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [REQS-1:0] rdy;
        logic [REQS-1:0] exp_p;
        rst_n     = 1'b0;
        req_valid = '0;
        req_ucp   = '0;
        req_line  = '0;
        cur_v     = '0;
        for (int i = 0; i < REQS; i++) begin
            cur_ucp[i]  = '0;
            cur_line[i] = '0;
        end
        model_reset();
        #2;
        check("reset_ready", req_ready, '0);
        check("reset_rsp", rsp_valid, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Requester 1 waits behind a permanently busy requester 0.
        for (int k = 0; k < 32; k++) begin
            set_hold(3'b011);
            issue_cycle(rdy);
            exp_p = (k % 16 == 15) ? 3'b010 : 3'b001;
            check("starve_pattern", rdy, exp_p);
        end
`ifdef FONT_GLYPH_ARBITER_STATS_EN
        check("stat_grants0", stat_grants[0 +: 16], 16'd30);
        check("stat_grants1", stat_grants[16 +: 16], 16'd2);
        check("stat_starve1", stat_starve[16 +: 16], 16'd2);
        check("stat_starve0", stat_starve[0 +: 16], 16'd0);
`endif
        idle(6);

        do_reset();
        cur_v       = 3'b001;
        cur_ucp[0]  = 21'h41;
        cur_line[0] = 4'd3;
        issue_cycle(rdy);
        check("single_grant", rdy, 3'b001);
        idle(6);

        for (int k = 0; k < 6; k++) begin
            set_hold(3'b110);
            issue_cycle(rdy);
            exp_p = (k % 2 == 0) ? 3'b010 : 3'b100;
            check("rr_alternate", rdy, exp_p);
        end
        idle(6);

        cur_v       = 3'b100;
        cur_ucp[2]  = 21'h1F600;
        cur_line[2] = 4'd5;
        issue_cycle(rdy);
        check("tofu_grant", rdy, 3'b100);
        idle(6);

        // Three back-to-back grants, then reset before any response emerges.
        cur_v = 3'b001; new_fields(0); issue_cycle(rdy); check("pre_rst_g0", rdy, 3'b001);
        cur_v = 3'b010; new_fields(1); issue_cycle(rdy); check("pre_rst_g1", rdy, 3'b010);
        cur_v = 3'b100; new_fields(2); issue_cycle(rdy); check("pre_rst_g2", rdy, 3'b100);
        do_reset();
        idle(6);

        // Leave the pointer on requester 2, reset, and confirm requester 1 is favoured again.
        cur_v = 3'b010; new_fields(1); issue_cycle(rdy); check("ptr_move", rdy, 3'b010);
        do_reset();
        set_hold(3'b110);
        issue_cycle(rdy);
        check("ptr_restart", rdy, 3'b010);
        idle(6);

        for (int k = 0; k < 400; k++) begin
            random_next();
            issue_cycle(rdy);
            if (k == 200) do_reset();
        end

        idle(LAT + 3);
        check("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/font_glyph_arbiter.md
Name: font_glyph_arbiter

Overview:
- Shares one font glyph lookup pipeline (fixed 4-cycle latency, one lookup accepted per cycle) between REQS requesters.
- Typical requesters: requester 0 is the textmode renderer (display-critical); the others are console/blitter/CPU glyph readback.
- Arbitrates every cycle and tags each issued lookup with its requester ID, so the result is routed back after the pipeline latency.
- Sits between the requesters and a single font_glyph instance.

Parameters:
- REQS, 3, number of requesters (2..8); requester 0 has priority.
- UCPW, 21, Unicode code point width (bits).
- HEIGHT, 16, glyph height; line index width LW = $clog2(HEIGHT).
- WIDTH, 8, glyph width (pixels).
- GLYPH_LAT, 4, font glyph pipeline latency (cycles); must match the glyph instance.
- STARVE_MAX, 15, cycles a waiting low-priority requester tolerates before it overrides requester 0 (1..255).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  REQS  per-requester lookup request.
- req_ready  out  REQS  grant; one-hot or zero; combinational from req_valid and state.
- req_ucp  in  REQS*UCPW  packed code points; requester i occupies [i*UCPW +: UCPW].
- req_line  in  REQS*LW  packed glyph line indices.
- rsp_valid  out  REQS  one-hot response strobe.
- rsp_pix  out  WIDTH  pixel line; shared by all requesters and qualified by rsp_valid.
- glyph_ucp  out  UCPW  to glyph ucp.
- glyph_line  out  LW  to glyph line_id.
- glyph_pix  in  WIDTH  from glyph pix_line.

Behaviour:
- Reset (rst_n low, asynchronous):
  - req_ready = 0 and rsp_valid = 0.
  - Round-robin pointer = 1; starvation counters = 0; tag pipeline cleared.
  - glyph_ucp/glyph_line drive 0.
  - In-flight lookups are dropped; no responses for them after reset releases.
- Issue rule: handshake = req_valid[i] & req_ready[i]. At most one per cycle.
  - In the handshake cycle, glyph_ucp/glyph_line combinationally carry the granted requester's fields.
  - With no grant they carry 0 and no tag is launched.
- Grant priority, evaluated per cycle:
  1. Starved: any requester j != 0 whose starvation counter == STARVE_MAX. If several are starved, the lowest index wins.
  2. Requester 0, if valid.
  3. Round-robin among 1..REQS-1:
     - Search starts at the pointer. After a grant to k from this step or step 1, the pointer becomes k+1, wrapping REQS-1 -> 1.
     - The pointer is unchanged when requester 0 wins.
- Starvation counter per requester j != 0:
  - Increments, saturating at STARVE_MAX, in each cycle with req_valid[j] & !req_ready[j].
  - Clears on grant or when req_valid[j] is low.
- Request stability: a requester holding req_valid keeps its fields stable until granted. The arbiter does not latch requests.
- Tag pipeline: GLYPH_LAT-deep shift register of {valid, id}, advancing every cycle (no backpressure).
  - A grant in cycle t produces rsp_valid[id] = 1 in cycle t+GLYPH_LAT.
  - rsp_pix = glyph_pix in that cycle (combinational pass-through).
  - Throughput is one response per cycle. Back-to-back grants to different requesters interleave responses in the same order.
- Requesters must accept responses unconditionally; no response stalling.
- REQS == 1 boundary is not supported; the minimum is 2.
- Widths: ids are $clog2(REQS) bits; the starvation counter is 8 bits.

Optional Feature:
- FONT_GLYPH_ARBITER_STATS_EN: adds outputs stat_grants (REQS*16) and stat_starve (REQS*16).
  - stat_grants: per-requester 16-bit wrapping grant counters.
  - stat_starve: count of grants issued via the starvation override (step 1).
  - Both clear on reset.
- Without the macro: these ports and counters do not exist; grant behaviour is identical.

Decomposition:
- Shared package font_pkg:
  - localparams GLYPH_LAT = 4, MISSING_ADDR = 'h11, REPLACE_ADDR = 'h7F.
  - Shared typedef for the {valid, id} tag.
- One sub-module, rr_pick: REQS-1 wide round-robin picker (request vector + pointer -> one-hot grant, next pointer), reused by other arbiters.

Test Plan:
- Reset then req_valid = 3'b001, ucp 'h41, line 3 -> req_ready = 001 the same cycle; rsp_valid = 001 four cycles later; rsp_pix = model glyph 'A' line 3.
- req_valid = 3'b110 held 6 cycles -> grants alternate 010, 100, 010, ...; responses 4 cycles later in the same order, one per cycle.
- req_valid = 3'b011 held continuously (STARVE_MAX = 15) -> requester 0 granted for 15 cycles, then requester 1 for exactly 1 cycle, then requester 0 again; pattern repeats.
- Grants to 0, 1, 2 on consecutive cycles, rst_n pulsed low asynchronously 2 cycles later -> rsp_valid stays 0 through and after reset; the pointer restarts at 1.
- Code point 'h1F600 issued by requester 2 -> rsp_valid = 100 at +4 with the tofu glyph line (missing-glyph index 'h11).
- With FONT_GLYPH_ARBITER_STATS_EN, run the third scenario for 32 cycles -> stat_grants[1] = 2, stat_starve[1] = 2, stat_grants[0] = 30.
